keypad_scanner: RTL and testbench

//   Input-side counterpart of the 7-segment display driver: scans a 4x4 matrix keypad
//   by driving one column low at a time and reading the rows.

---
 rtl/keypad_scanner.sv | 199 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, per-scan classification, debounce FSM,
// one-cycle key strobe and a 4-digit BCD shift-in entry register.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_0,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] digit_3
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    // Indexed by {row, col}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [3:0]         cand, cand_next;
    logic               accept, go_idle;

    logic [3:0]         row_s1, row_s2;
    logic [DIV_W-1:0]   div;
    logic [1:0]         col;
    logic [1:0]         acc_n;
    logic [3:0]         acc_code;

    logic               tick, scan_done;
    logic [3:0]         hits;
    logic [2:0]         col_hits, sum;
    logic [1:0]         first_row, merged_n;
    logic [3:0]         merged_code;
    logic               res_none, res_one;

    assign col_n     = ~(4'b0001 << col);
    assign tick      = (div == DIV_W'(SCAN_DIV - 1));
    assign scan_done = tick && (col == 2'd3);

    // Merge this column's pressed rows into the running per-scan tally (saturates at 2 = MULTI).
    assign hits     = ~row_s2;
    assign col_hits = 3'($countones(hits));
    assign sum      = {1'b0, acc_n} + col_hits;
    assign merged_n = (sum >= 3'd2) ? 2'd2 : sum[1:0];

    always_comb begin
        first_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hits[i]) first_row = 2'(i);
        end
    end

    assign merged_code = (acc_n == 2'd0) ? KEY_MAP[{first_row, col}] : acc_code;
    assign res_none    = (merged_n == 2'd0);
    assign res_one     = (merged_n == 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1   <= 4'hF;
            row_s2   <= 4'hF;
            div      <= '0;
            col      <= 2'd0;
            acc_n    <= 2'd0;
            acc_code <= 4'h0;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
            if (tick) begin
                div <= '0;
                col <= (col == 2'd3) ? 2'd0 : col + 2'd1;
                if (col == 2'd3) begin
                    acc_n    <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_n    <= merged_n;
                    acc_code <= merged_code;
                end
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        accept     = 1'b0;
        go_idle    = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (res_one) begin
                        cand_next = merged_code;
                        cnt_next  = CNT_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            accept     = 1'b1;
                            cnt_next   = '0;
                            state_next = HELD;
                        end else begin
                            state_next = PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (res_one && merged_code == cand) begin
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
                            accept     = 1'b1;
                            cnt_next   = '0;
                            state_next = HELD;
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
                HELD: begin
                    if (res_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            go_idle    = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else begin
                            cnt_next   = CNT_W'(1);
                            state_next = REL_PEND;
                        end
                    end
                end
                REL_PEND: begin
                    if (res_none) begin
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
                            go_idle    = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = HELD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            digit_0   <= 4'h0;
            digit_1   <= 4'h0;
            digit_2   <= 4'h0;
            digit_3   <= 4'h0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cand      <= cand_next;
            key_valid <= accept;
            if (accept) begin
                key_code <= cand_next;
                key_held <= 1'b1;
                if (cand_next <= 4'd9) begin
                    digit_3 <= digit_2;
                    digit_2 <= digit_1;
                    digit_1 <= digit_0;
                    digit_0 <= cand_next;
                end else if (cand_next == 4'hC) begin
                    digit_3 <= 4'h0;
                    digit_2 <= 4'h0;
                    digit_1 <= 4'h0;
                    digit_0 <= 4'h0;
                end
            end
            if (go_idle) key_held <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a virtual keypad matrix, a per-scan debounce reference model,
// a table of entry sequences, hand-written corner cases and randomized key patterns.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n, col_n, key_code;
    logic       key_valid, key_held;
    logic [3:0] digit_0, digit_1, digit_2, digit_3;

    logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c pressed

    int n_checks = 0;
    int n_pass   = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_n[c] && keys[r*4+c]) row_n[r] = 1'b0;
    end

    logic [3:0] keymap [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [15:0] kb(input logic [3:0] code);
        logic [15:0] m = 16'h0;
        for (int i = 0; i < 16; i++)
            if (keymap[i] == code) m[i] = 1'b1;
        return m;
    endfunction

    // Reference model: tracks runs of identical single-key scans and runs of empty scans.
    bit         m_held;
    int         m_run, m_none;
    logic [3:0] m_key, m_code;
    logic [15:0] m_dig;

    task automatic model_reset();
        m_held = 0; m_run = 0; m_none = 0; m_key = 0; m_code = 0; m_dig = 0;
    endtask

    task automatic model_scan(input logic [15:0] k, output bit acc);
        int n;
        logic [3:0] code;
        n = $countones(k);
        code = 4'h0;
        for (int i = 0; i < 16; i++) if (k[i]) code = keymap[i];
        acc = 0;
        if (!m_held) begin
            if (n == 1 && m_run > 0 && code == m_key) m_run++;
            else if (n == 1 && m_run == 0) begin m_key = code; m_run = 1; end
            else m_run = 0;
            if (m_run == DB) begin
                acc = 1; m_held = 1; m_none = 0; m_code = m_key;
                if (m_key <= 4'd9) m_dig = {m_dig[11:0], m_key};
                else if (m_key == 4'hC) m_dig = 16'h0;
            end
        end else begin
            if (n == 0) m_none++;
            else m_none = 0;
            if (m_none == DB) begin m_held = 0; m_run = 0; end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Called at a negedge that is aligned to a scan boundary; runs one full 16-cycle scan.
    task automatic run_scan(input logic [15:0] k);
        bit acc;
        int col_err = 0, mid = 0;
        keys = k;
        for (int i = 0; i < 4*SD; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (col_n !== ~(4'b0001 << (((i + 1) / SD) % 4))) col_err++;
            if (i < 4*SD - 1 && key_valid) mid++;
        end
        model_scan(k, acc);
        check("col_rotation", col_err, 0);
        check("mid_scan_strobe", mid, 0);
        check("key_valid", key_valid, acc);
        check("key_code", key_code, m_code);
        check("key_held", key_held, m_held);
        check("digits", {digit_3, digit_2, digit_1, digit_0}, m_dig);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        keys = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        check("rst_digits", {digit_3, digit_2, digit_1, digit_0}, 0);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [3:0]  exp_code;
        logic [15:0] exp_dig;
    } entry_t;

    entry_t tbl [9];

    initial begin
        int strobes;
        tbl[0] = '{4'h1, 4'h1, 16'h0001};
        tbl[1] = '{4'h2, 4'h2, 16'h0012};
        tbl[2] = '{4'h3, 4'h3, 16'h0123};
        tbl[3] = '{4'h4, 4'h4, 16'h1234};
        tbl[4] = '{4'h9, 4'h9, 16'h2349};
        tbl[5] = '{4'hC, 4'hC, 16'h0000};
        tbl[6] = '{4'h7, 4'h7, 16'h0007};
        tbl[7] = '{4'hF, 4'hF, 16'h0007};
        tbl[8] = '{4'hA, 4'hA, 16'h0007};

        // Reset state and column rotation
        do_reset();
        run_scan(16'h0);

        // Hold '5' for 8 scans: single strobe at the end of scan 3, then release
        strobes = 0;
        for (int s = 0; s < 8; s++) begin
            run_scan(kb(4'h5));
            if (s == 2) check("five_strobe_scan3", key_valid, 1);
            strobes += int'(key_valid);
        end
        check("five_strobe_count", strobes, 1);
        check("five_digit0", digit_0, 4'h5);
        run_scan(16'h0);
        run_scan(16'h0);
        check("five_still_held", key_held, 1);
        run_scan(16'h0);
        check("five_released", key_held, 0);

        // Bouncing '7': never stable long enough
        for (int r = 0; r < 6; r++) begin
            run_scan(kb(4'h7));
            run_scan(16'h0);
        end
        check("bounce_digits", {digit_3, digit_2, digit_1, digit_0}, 16'h0005);

        // Table-driven entry sequence
        do_reset();
        foreach (tbl[i]) begin
            repeat (DB) run_scan(kb(tbl[i].key));
            check("tbl_code", key_code, tbl[i].exp_code);
            check("tbl_digits", {digit_3, digit_2, digit_1, digit_0}, tbl[i].exp_dig);
            repeat (DB) run_scan(16'h0);
        end

        // Two keys together, then '#', then a second key while '#' held
        do_reset();
        repeat (4) run_scan(kb(4'h1) | kb(4'h2));
        repeat (2) run_scan(16'h0);
        repeat (3) run_scan(kb(4'hF));
        check("hash_code", key_code, 4'hF);
        repeat (4) run_scan(kb(4'hF) | kb(4'h8));
        check("hash_plus_8_code", key_code, 4'hF);
        repeat (4) run_scan(16'h0);

        // Reset in the middle of PRESS_PEND
        repeat (2) run_scan(kb(4'h5));
        keys = kb(4'h5);
        for (int i = 0; i < 5; i++) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_col_n", col_n, 4'b1110);
        check("midrst_key_valid", key_valid, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_scan(kb(4'h5));
        run_scan(kb(4'h5));
        check("restart_no_early", key_held, 0);
        run_scan(kb(4'h5));
        check("restart_strobe", key_valid, 1);
        repeat (4) run_scan(16'h0);

        // Randomized key patterns against the model
        for (int g = 0; g < 40; g++) begin
            logic [15:0] k;
            int sel, len;
            sel = $urandom_range(0, 9);
            if (sel < 4) k = 16'h0;
            else if (sel < 8) begin
                case ($urandom_range(0, 2))
                    0: k = kb(4'h5);
                    1: k = kb(4'h7);
                    default: k = kb(4'hC);
                endcase
            end else begin
                int a, b;
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                k = 16'h0;
                k[a] = 1'b1;
                k[b] = 1'b1;
            end
            len = $urandom_range(1, 4);
            repeat (len) run_scan(k);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
